// File: rtl/mem_rd_cmd_responder.sv
// mem_rd_cmd_responder: turns (address, length) read commands into 4 KB-safe AXI4 read bursts and
// returns the data as one keep/last-framed stream packet followed by one completion status byte.
// Ports: clk, rst_n (synchronous, active low)
//        cmd_valid/cmd_ready/cmd_address/cmd_length           command slave
//        m_axi_ar* / m_axi_r*                                  AXI4 read master (fixed ID, INCR, 64 B beats)
//        m_axis_valid/ready/data/keep/last                     data stream out
//        status_valid/status_ready/status_data                 [0] rresp err [1] rlast mismatch [2] unaligned [3] zero len
module mem_rd_cmd_responder #(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 33,
    parameter int AXI_ID          = 0,
    parameter int MAX_BURST       = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [63:0]             cmd_address,
    input  logic [31:0]             cmd_length,
    output logic [5:0]              m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic                    m_axis_valid,
    input  logic                    m_axis_ready,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    output logic [DATA_WIDTH/8-1:0] m_axis_keep,
    output logic                    m_axis_last,
    output logic                    status_valid,
    input  logic                    status_ready,
    output logic [7:0]              status_data
);
    localparam int KW = DATA_WIDTH / 8;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, RUN, STATUS} state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d, r_addr_q, r_addr_d, araddr_q, araddr_d;
    logic [32:0]           ar_left_q, ar_left_d, r_left_q, r_left_d;
    logic [32:0]           beats_q, beats_d, beat_cnt_q, beat_cnt_d, r_pos_q, r_pos_d;
    logic [7:0]            arlen_q, arlen_d, status_q, status_d;
    logic [5:0]            rem_q, rem_d;
    logic [OW-1:0]         outst_q, outst_d;
    logic                  arvalid_q, arvalid_d, axis_valid_q, axis_valid_d, axis_last_q, axis_last_d;
    logic [DATA_WIDTH-1:0] axis_data_q, axis_data_d;
    logic [KW-1:0]         axis_keep_q, axis_keep_d;
    logic [32:0]           ar_blen, r_blen, cmd_beats;
    logic                  accept, ar_hs, r_hs, axis_hs, r_end, r_final, ar_issue;
    logic                  unused_ok;

    // Beats of the burst starting at a: capped by what is left, MAX_BURST and the next 4 KB boundary.
    function automatic logic [32:0] burst_beats(input logic [ADDR_WIDTH-1:0] a, input logic [32:0] left);
        logic [32:0] b;
        b = 33'd64 - 33'(a[11:6]);
        if (33'(MAX_BURST) < b) b = 33'(MAX_BURST);
        if (left < b) b = left;
        return b;
    endfunction

    assign unused_ok = ^cmd_address[63:ADDR_WIDTH];
    assign cmd_beats = (33'(cmd_length) + 33'd63) >> 6;
    assign accept    = cmd_valid && cmd_ready_q;
    assign ar_hs     = arvalid_q && m_axi_arready;
    assign r_hs      = m_axi_rvalid && m_axi_rready;
    assign axis_hs   = axis_valid_q && m_axis_ready;
    // The R side replays the AR split so it knows where each burst should end, independent of rlast.
    assign ar_blen   = burst_beats(ar_addr_q, ar_left_q);
    assign r_blen    = burst_beats(r_addr_q, r_left_q);
    assign r_end     = r_pos_q + 33'd1 == r_blen;
    assign r_final   = beat_cnt_q + 33'd1 == beats_q;
    // Only one AR is ever pending, so outstanding is exact whenever a new one is raised.
    assign ar_issue  = state_q == RUN && !arvalid_q && ar_left_q != 33'd0 && outst_q < OW'(MAX_OUTSTANDING);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            ar_addr_q    <= '0;
            r_addr_q     <= '0;
            araddr_q     <= '0;
            ar_left_q    <= '0;
            r_left_q     <= '0;
            beats_q      <= '0;
            beat_cnt_q   <= '0;
            r_pos_q      <= '0;
            arlen_q      <= '0;
            status_q     <= '0;
            rem_q        <= '0;
            outst_q      <= '0;
            arvalid_q    <= 1'b0;
            axis_valid_q <= 1'b0;
            axis_last_q  <= 1'b0;
            axis_data_q  <= '0;
            axis_keep_q  <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            ar_addr_q    <= ar_addr_d;
            r_addr_q     <= r_addr_d;
            araddr_q     <= araddr_d;
            ar_left_q    <= ar_left_d;
            r_left_q     <= r_left_d;
            beats_q      <= beats_d;
            beat_cnt_q   <= beat_cnt_d;
            r_pos_q      <= r_pos_d;
            arlen_q      <= arlen_d;
            status_q     <= status_d;
            rem_q        <= rem_d;
            outst_q      <= outst_d;
            arvalid_q    <= arvalid_d;
            axis_valid_q <= axis_valid_d;
            axis_last_q  <= axis_last_d;
            axis_data_q  <= axis_data_d;
            axis_keep_q  <= axis_keep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && accept) state_d = cmd_length == 32'd0 ? STATUS : RUN;
        if (state_q == RUN && axis_hs && axis_last_q) state_d = STATUS;
        if (state_q == STATUS && status_ready) state_d = IDLE;
        cmd_ready_d = state_d == IDLE;
    end

    always_comb begin
        ar_addr_d    = ar_addr_q;
        r_addr_d     = r_addr_q;
        araddr_d     = araddr_q;
        ar_left_d    = ar_left_q;
        r_left_d     = r_left_q;
        beats_d      = beats_q;
        beat_cnt_d   = beat_cnt_q;
        r_pos_d      = r_pos_q;
        arlen_d      = arlen_q;
        status_d     = status_q;
        rem_d        = rem_q;
        arvalid_d    = arvalid_q && !m_axi_arready;
        axis_valid_d = axis_valid_q && !m_axis_ready;
        axis_last_d  = axis_last_q;
        axis_data_d  = axis_data_q;
        axis_keep_d  = axis_keep_q;
        outst_d      = outst_q + OW'(ar_hs) - OW'(r_hs && m_axi_rlast);
        if (state_q == IDLE && accept) begin
            ar_addr_d  = {cmd_address[ADDR_WIDTH-1:6], 6'd0};
            r_addr_d   = {cmd_address[ADDR_WIDTH-1:6], 6'd0};
            ar_left_d  = cmd_beats;
            r_left_d   = cmd_beats;
            beats_d    = cmd_beats;
            beat_cnt_d = '0;
            r_pos_d    = '0;
            rem_d      = cmd_length[5:0];
            outst_d    = '0;
            status_d   = {4'd0, cmd_length == 32'd0, cmd_address[5:0] != 6'd0, 2'd0};
        end
        if (ar_issue) begin
            arvalid_d = 1'b1;
            araddr_d  = ar_addr_q;
            arlen_d   = 8'(ar_blen - 33'd1);
            ar_addr_d = ar_addr_q + ADDR_WIDTH'(ar_blen << 6);
            ar_left_d = ar_left_q - ar_blen;
        end
        if (r_hs) begin
            axis_valid_d = 1'b1;
            axis_data_d  = m_axi_rdata;
            axis_last_d  = r_final;
            axis_keep_d  = r_final && rem_q != 6'd0 ? ~({KW{1'b1}} << rem_q) : {KW{1'b1}};
            beat_cnt_d   = beat_cnt_q + 33'd1;
            status_d[0]  = status_q[0] | (m_axi_rresp != 2'b00);
            status_d[1]  = status_q[1] | (m_axi_rlast != r_end);
            r_pos_d      = r_end ? 33'd0 : r_pos_q + 33'd1;
            r_addr_d     = r_end ? r_addr_q + ADDR_WIDTH'(r_blen << 6) : r_addr_q;
            r_left_d     = r_end ? r_left_q - r_blen : r_left_q;
        end
    end

    always_comb begin
        cmd_ready     = cmd_ready_q;
        status_valid  = state_q == STATUS;
        status_data   = status_q;
        m_axi_rready  = state_q == RUN && (!axis_valid_q || m_axis_ready);
        m_axi_arid    = 6'(AXI_ID);
        m_axi_araddr  = araddr_q;
        m_axi_arlen   = arlen_q;
        m_axi_arsize  = 3'd6;
        m_axi_arburst = 2'b01;
        m_axi_arvalid = arvalid_q;
        m_axis_valid  = axis_valid_q;
        m_axis_data   = axis_data_q;
        m_axis_keep   = axis_keep_q;
        m_axis_last   = axis_last_q;
    end
endmodule
